// File: rtl/cpu_pkg.sv
// Shared constants and the output-side state encoding for the CPU I/O terminal.
package cpu_pkg;

   localparam int BITS_DEFAULT = 16;
   localparam int FIFO_DEPTH   = 4;

   typedef enum logic [1:0] {
      OUT_IDLE,
      OUT_CAPTURE,
      OUT_SEND
   } out_state_e;

endpackage

// File: rtl/io_terminal_if.sv
// Host-side character handshakes of the I/O terminal: one valid/ready channel each way.
interface io_terminal_if #(parameter int Bits = cpu_pkg::BITS_DEFAULT);

   logic [Bits-1:0] host_in_data;
   logic            host_in_valid;
   logic            host_in_ready;
   logic [Bits-1:0] host_out_data;
   logic            host_out_valid;
   logic            host_out_ready;

   // master is the external host, slave is the terminal block.
   modport master (
      output host_in_data, host_in_valid, host_out_ready,
      input  host_in_ready, host_out_data, host_out_valid
   );

   modport slave (
      input  host_in_data, host_in_valid, host_out_ready,
      output host_in_ready, host_out_data, host_out_valid
   );

endinterface

// File: rtl/io_fifo.sv
// Four-entry input character FIFO; head is presented combinationally on pop_data.
module io_fifo
   import cpu_pkg::*;
#(
   parameter int Bits = BITS_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [Bits-1:0] push_data,
   input  logic            pop,
   output logic [Bits-1:0] pop_data,
   output logic            full,
   output logic            empty
);

   logic [1:0]      wr_ptr_q, wr_ptr_d;
   logic [1:0]      rd_ptr_q, rd_ptr_d;
   logic [2:0]      count_q,  count_d;
   logic [Bits-1:0] mem_q [FIFO_DEPTH];
   logic [Bits-1:0] mem_d [FIFO_DEPTH];
   logic            do_push, do_pop;

   assign full     = (count_q == 3'(FIFO_DEPTH));
   assign empty    = (count_q == 3'd0);
   assign pop_data = mem_q[rd_ptr_q];
   assign do_pop   = pop & ~empty;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign do_push  = push & (~full | do_pop);

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/io_terminal.sv
// CPU I/O terminal: INPR/FGI input path and OUTR/FGO output path with host handshakes.
// Define IO_TERMINAL_INFIFO_EN to place a 4-entry FIFO in front of INPR.
module io_terminal
   import cpu_pkg::*;
#(
   parameter int Bits = BITS_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   io_terminal_if.slave    host,
   output logic [Bits-1:0] inpr_data,
   output logic            fgi,
   input  logic            inp_ack,
   input  logic [Bits-1:0] outr_data,
   input  logic            out_strobe,
   output logic            fgo,
   output logic            ovr
);

   logic [Bits-1:0] inpr_q, inpr_d;
   logic            fgi_q, fgi_d;
   logic            in_push;
   out_state_e      state_q, state_d;
   logic [Bits-1:0] out_data_q, out_data_d;
   logic            ovr_q, ovr_d;

`ifdef IO_TERMINAL_INFIFO_EN
   logic            fifo_full, fifo_empty, fifo_pop;
   logic [Bits-1:0] fifo_head;

   assign host.host_in_ready = ~reset & ~fifo_full;
   assign in_push            = host.host_in_valid & host.host_in_ready;
   // Refill INPR when it is free or is being consumed this cycle, so FGI never bubbles.
   assign fifo_pop           = ~fifo_empty & (~fgi_q | inp_ack);

   io_fifo #(.Bits(Bits)) u_in_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_push),
      .push_data (host.host_in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      inpr_d = inpr_q;
      fgi_d  = fgi_q;
      if (fifo_pop) begin
         inpr_d = fifo_head;
         fgi_d  = 1'b1;
      end else if (inp_ack) begin
         fgi_d  = 1'b0;
      end
   end
`else
   assign host.host_in_ready = ~reset & ~fgi_q;
   assign in_push            = host.host_in_valid & host.host_in_ready;

   always_comb begin
      inpr_d = inpr_q;
      fgi_d  = fgi_q;
      if (in_push) begin
         inpr_d = host.host_in_data;
         fgi_d  = 1'b1;
      end else if (inp_ack) begin
         fgi_d  = 1'b0;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      ovr_d      = ovr_q | (out_strobe & (state_q != OUT_IDLE));
      case (state_q)
         OUT_IDLE:    if (out_strobe) state_d = OUT_CAPTURE;
         OUT_CAPTURE: begin
            out_data_d = outr_data;
            state_d    = OUT_SEND;
         end
         OUT_SEND:    if (host.host_out_ready) state_d = OUT_IDLE;
         default:     state_d = OUT_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inpr_q     <= '0;
         fgi_q      <= 1'b0;
         state_q    <= OUT_IDLE;
         out_data_q <= '0;
         ovr_q      <= 1'b0;
      end else begin
         inpr_q     <= inpr_d;
         fgi_q      <= fgi_d;
         state_q    <= state_d;
         out_data_q <= out_data_d;
         ovr_q      <= ovr_d;
      end
   end

   assign inpr_data           = inpr_q;
   assign fgi                 = fgi_q;
   assign fgo                 = (state_q == OUT_IDLE);
   assign ovr                 = ovr_q;
   assign host.host_out_data  = out_data_q;
   assign host.host_out_valid = (state_q == OUT_SEND);

endmodule

// File: tb/tb_io_terminal.sv
// Self-checking bench for io_terminal: directed scenarios plus random traffic against a queue model.
module tb_io_terminal;

   localparam int Bits = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [Bits-1:0] inpr_data, outr_data;
   logic            fgi, inp_ack, out_strobe, fgo, ovr;

   int errors = 0;
   int checks = 0;

   io_terminal_if #(.Bits(Bits)) host ();

   io_terminal #(.Bits(Bits)) dut (
      .clk        (clk),
      .reset      (reset),
      .host       (host),
      .inpr_data  (inpr_data),
      .fgi        (fgi),
      .inp_ack    (inp_ack),
      .outr_data  (outr_data),
      .out_strobe (out_strobe),
      .fgo        (fgo),
      .ovr        (ovr)
   );

   always #5 clk = ~clk;

   // Reference model: input side is INPR plus a queue of waiting characters;
   // output side tracks how many cycles a character has been in service.
   logic [Bits-1:0] m_inpr;
   bit              m_fgi;
   logic [Bits-1:0] m_q[$];
   bit              m_busy;
   int              m_age;
   logic [Bits-1:0] m_out;
   bit              m_ovr;

   function automatic bit m_ready();
`ifdef IO_TERMINAL_INFIFO_EN
      return m_q.size() < 4;
`else
      return !m_fgi;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst, input bit v, input logic [Bits-1:0] d, input bit ack,
                             input logic [Bits-1:0] outr, input bit strobe, input bit ordy);
      bit acc;
      bit pop;
      if (rst) begin
         m_inpr = '0; m_fgi = 0; m_q.delete();
         m_busy = 0; m_age = 0; m_out = '0; m_ovr = 0;
         return;
      end
      acc = v && m_ready();
`ifdef IO_TERMINAL_INFIFO_EN
      pop = (m_q.size() > 0) && (!m_fgi || ack);
      if (pop) begin
         m_inpr = m_q.pop_front();
         m_fgi  = 1;
      end else if (ack) m_fgi = 0;
      if (acc) m_q.push_back(d);
`else
      pop = 0;
      if (acc) begin
         m_inpr = d;
         m_fgi  = 1;
      end else if (ack) m_fgi = 0;
`endif
      if (!m_busy) begin
         if (strobe) begin
            m_busy = 1;
            m_age  = 1;
         end
      end else begin
         if (strobe) m_ovr = 1;
         if (m_age == 1) begin
            m_out = outr;
            m_age = 2;
         end else if (ordy) begin
            m_busy = 0;
            m_age  = 0;
         end
      end
   endtask

   task automatic check_state();
      check("inpr_data", inpr_data, m_inpr);
      check("fgi", fgi, m_fgi);
      check("fgo", fgo, !m_busy);
      check("host_out_valid", host.host_out_valid, m_busy && m_age == 2);
      check("host_out_data", host.host_out_data, m_out);
      check("ovr", ovr, m_ovr);
   endtask

   task automatic cycle(input bit rst, input bit v, input logic [Bits-1:0] d, input bit ack,
                        input logic [Bits-1:0] outr, input bit strobe, input bit ordy);
      @(negedge clk);
      reset                = rst;
      host.host_in_valid   = v;
      host.host_in_data    = d;
      inp_ack              = ack;
      outr_data            = outr;
      out_strobe           = strobe;
      host.host_out_ready  = ordy;
      #1;
      check("host_in_ready", host.host_in_ready, rst ? 1'b0 : m_ready());
      @(posedge clk);
      model_edge(rst, v, d, ack, outr, strobe, ordy);
      #1;
      check_state();
   endtask

   task automatic idle(input int n, input logic [Bits-1:0] outr);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, outr, 0, 0);
   endtask

   initial begin
      reset = 1'b1; host.host_in_valid = 0; host.host_in_data = '0; inp_ack = 0;
      outr_data = '0; out_strobe = 0; host.host_out_ready = 0;

      // Reset then idle
      cycle(1, 0, '0, 0, '0, 0, 0);
      cycle(1, 0, '0, 0, '0, 0, 0);
      idle(1, '0);
      check("idle_fgo", fgo, 1'b1);
      check("idle_fgi", fgi, 1'b0);
      check("idle_ready", host.host_in_ready, 1'b1);

      // Single input character, then consume it
      cycle(0, 1, 16'h0041, 0, '0, 0, 0);
      idle(1, '0);
      check("in_char", inpr_data, 16'h0041);
      check("in_fgi", fgi, 1'b1);
      cycle(0, 0, '0, 1, '0, 0, 0);
      check("ack_fgi", fgi, 1'b0);
      check("ack_keep", inpr_data, 16'h0041);

      // Output character with host stalled, overrun during send, then release
      cycle(0, 0, '0, 0, 16'h0042, 1, 0);
      check("cap_fgo", fgo, 1'b0);
      check("cap_valid", host.host_out_valid, 1'b0);
      idle(1, 16'h0042);
      check("send_valid", host.host_out_valid, 1'b1);
      idle(2, 16'h0042);
      cycle(0, 0, '0, 0, 16'h0099, 1, 0);
      check("ovr_set", ovr, 1'b1);
      check("ovr_data", host.host_out_data, 16'h0042);
      idle(2, 16'h0099);
      check("held_data", host.host_out_data, 16'h0042);
      cycle(0, 0, '0, 0, 16'h0099, 0, 1);
      check("release_fgo", fgo, 1'b1);
      check("ovr_sticky", ovr, 1'b1);

      // Back-to-back output service with host always ready
      for (int i = 0; i < 6; i++) cycle(0, 0, '0, 0, 16'h0100 + 16'(i), 1, 1);

      // Reset while sending and with fgi set
      cycle(0, 1, 16'h0055, 0, 16'h0077, 1, 0);
      idle(3, 16'h0077);
      check("pre_rst_valid", host.host_out_valid, 1'b1);
      check("pre_rst_fgi", fgi, 1'b1);
      cycle(1, 1, 16'h0066, 1, 16'h0088, 1, 1);
      check("rst_inpr", inpr_data, 16'h0000);
      check("rst_valid", host.host_out_valid, 1'b0);
      check("rst_ovr", ovr, 1'b0);
      check("rst_fgo", fgo, 1'b1);

`ifdef IO_TERMINAL_INFIFO_EN
      // Fill the FIFO behind INPR, then drain with back-to-back acks
      idle(1, '0);
      for (int k = 1; k <= 5; k++) cycle(0, 1, 16'(k), 0, '0, 0, 0);
      idle(1, '0);
      check("fifo_head", inpr_data, 16'd1);
      check("fifo_full_ready", host.host_in_ready, 1'b0);
      for (int k = 2; k <= 5; k++) begin
         cycle(0, 0, '0, 1, '0, 0, 0);
         check("fifo_drain", inpr_data, 16'(k));
         check("fifo_drain_fgi", fgi, 1'b1);
      end
      // Push and pop together while full
      for (int k = 6; k <= 9; k++) cycle(0, 1, 16'(k), 0, '0, 0, 0);
      cycle(0, 1, 16'd10, 1, '0, 0, 0);
      idle(1, '0);
`endif

      // Random traffic on both paths
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               $urandom_range(0, 1) == 1,
               16'($urandom),
               $urandom_range(0, 9) < 3,
               16'($urandom),
               $urandom_range(0, 9) < 2,
               $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
